// File: rtl/fp32_mul_seq.sv
// IEEE 754 single-precision multiplier with an iterative radix-2 shift-add core.
// Truncating rounding; handles denormals, NaN, Inf and signed zero.
module fp32_mul_seq #(
   parameter logic [31:0] QNAN = 32'h7FC00001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result
);

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic [47:0]        mcand_q, mcand_d;
   logic [23:0]        mplier_q, mplier_d;
   logic [47:0]        acc_q, acc_d;
   logic [4:0]         cnt_q, cnt_d;
   logic signed [10:0] exp_sum_q, exp_sum_d;
   logic               special_q, special_d;
   logic [31:0]        special_res_q, special_res_d;
   logic [31:0]        result_q, result_d;

   logic [7:0]         ea, eb, eff_ea, eff_eb;
   logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;
   logic [5:0]         lz;
   logic               lz_found;
   logic signed [10:0] norm_exp, shamt;
   logic [22:0]        norm_frac, den_frac;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;

   always_comb begin
      ea      = a[30:23];
      eb      = b[30:23];
      eff_ea  = (ea == 8'd0) ? 8'd1 : ea;
      eff_eb  = (eb == 8'd0) ? 8'd1 : eb;
      a_nan   = (&ea) && (|a[22:0]);
      b_nan   = (&eb) && (|b[22:0]);
      a_inf   = (&ea) && !(|a[22:0]);
      b_inf   = (&eb) && !(|b[22:0]);
      a_zero  = !(|ea) && !(|a[22:0]);
      b_zero  = !(|eb) && !(|b[22:0]);
      op_sign = a[31] ^ b[31];
   end

   // Leading-zero count of the product measured from bit 46 (the unit position).
   always_comb begin
      lz       = '0;
      lz_found = 1'b0;
      for (int unsigned i = 0; i < 47; i++) begin
         if (!lz_found) begin
            if (acc_q[46 - i]) lz_found = 1'b1;
            else               lz = lz + 6'd1;
         end
      end
   end

   always_comb begin
      if (acc_q[47]) begin
         norm_exp  = exp_sum_q + 11'sd1;
         norm_frac = acc_q[46:24];
      end else begin
         norm_exp  = exp_sum_q - $signed({5'b0, lz});
         norm_frac = 23'((acc_q << lz) >> 23);
      end
      shamt    = 11'sd1 - norm_exp;
      den_frac = 23'({1'b1, norm_frac} >> shamt[4:0]);
   end

   always_comb begin
      state_d       = state_q;
      sign_d        = sign_q;
      mcand_d       = mcand_q;
      mplier_d      = mplier_q;
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      exp_sum_d     = exp_sum_q;
      special_d     = special_q;
      special_res_d = special_res_q;
      result_d      = result_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d    = op_sign;
               mcand_d   = {24'b0, (ea != 8'd0), a[22:0]};
               mplier_d  = {(eb != 8'd0), b[22:0]};
               exp_sum_d = $signed({3'b0, eff_ea}) + $signed({3'b0, eff_eb}) - 11'sd127;
               acc_d     = '0;
               cnt_d     = '0;
               special_d = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
               if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
                  special_res_d = QNAN;
               else if (a_inf || b_inf)
                  special_res_d = {op_sign, 8'hFF, 23'b0};
               else
                  special_res_d = {op_sign, 31'b0};
               state_d = MUL;
            end
         end
         MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd23) state_d = NORM;
         end
         NORM: begin
            if (special_q)
               result_d = special_res_q;
            else if (acc_q == 48'd0)
               result_d = {sign_q, 31'b0};
            else if (norm_exp >= 11'sd255)
               result_d = {sign_q, 8'hFF, 23'b0};
            else if (norm_exp <= 11'sd0) begin
               if (shamt >= 11'sd24) result_d = {sign_q, 31'b0};
               else                  result_d = {sign_q, 8'h00, den_frac};
            end else
               result_d = {sign_q, norm_exp[7:0], norm_frac};
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sign_q        <= 1'b0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         acc_q         <= '0;
         cnt_q         <= '0;
         exp_sum_q     <= '0;
         special_q     <= 1'b0;
         special_res_q <= '0;
         result_q      <= '0;
      end else begin
         state_q       <= state_d;
         sign_q        <= sign_d;
         mcand_q       <= mcand_d;
         mplier_q      <= mplier_d;
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         exp_sum_q     <= exp_sum_d;
         special_q     <= special_d;
         special_res_q <= special_res_d;
         result_q      <= result_d;
      end
   end

endmodule
